// File: rtl/change_pkg.sv
// Shared coin codes, controller state encoding and coin-code legality check
// for the change dispense controller.
package change_pkg;

    localparam logic [2:0] COIN_NONE    = 3'd0;
    localparam logic [2:0] COIN_NICKEL  = 3'd1;
    localparam logic [2:0] COIN_DIME    = 3'd2;
    localparam logic [2:0] COIN_QUARTER = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SELECT,
        DISPENSE,
        DONE
    } state_e;

    function automatic logic coin_legal(input logic [2:0] code);
        return (code == COIN_NICKEL) || (code == COIN_DIME) || (code == COIN_QUARTER);
    endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy change picker: largest coin that fits the owed amount and is in stock.
module change_coin_select
    import change_pkg::*;
#(
    parameter int unsigned AMT_W = 6,
    parameter int unsigned CNT_W = 3
) (
    input  logic [AMT_W-1:0] change,
    input  logic [CNT_W-1:0] inv_q,
    input  logic [CNT_W-1:0] inv_d,
    input  logic [CNT_W-1:0] inv_n,
    output logic [2:0]       coin_c,
    output logic             none_avail
);

    always_comb begin
        coin_c = COIN_NONE;
        if (change >= AMT_W'(COIN_QUARTER) && inv_q != '0) begin
            coin_c = COIN_QUARTER;
        end else if (change >= AMT_W'(COIN_DIME) && inv_d != '0) begin
            coin_c = COIN_DIME;
        end else if (change != '0 && inv_n != '0) begin
            coin_c = COIN_NICKEL;
        end
    end

    assign none_avail = (coin_c == COIN_NONE);

endmodule

// File: rtl/change_dispense_ctrl.sv
// Vending transaction controller: collects coins against a cost, then pays
// change or a refund one coin at a time through a valid/ready ejector.
module change_dispense_ctrl
    import change_pkg::*;
#(
    parameter int unsigned AMT_W = 6,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] cost,
    input  logic             coin_in_valid,
    input  logic [2:0]       coin_in,
    input  logic             cancel,
    input  logic             inv_load,
    input  logic [CNT_W-1:0] inv_q_d,
    input  logic [CNT_W-1:0] inv_d_d,
    input  logic [CNT_W-1:0] inv_n_d,
    input  logic             dispense_ready,
    output logic             busy,
    output logic [AMT_W-1:0] paid,
    output logic             need_more,
    output logic             coin_reject,
    output logic             dispense_valid,
    output logic [2:0]       dispense_coin,
    output logic             done,
    output logic             short_change,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] inv_q,
    output logic [CNT_W-1:0] inv_d,
    output logic [CNT_W-1:0] inv_n
);

    localparam int unsigned SUM_W = AMT_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_e           state, state_nx;
    logic [AMT_W-1:0] cost_q, change_q;
    logic [AMT_W-1:0] cost_nx, paid_nx, change_nx, rem_nx;
    logic [CNT_W-1:0] inv_q_nx, inv_d_nx, inv_n_nx;
    logic [2:0]       coin_nx, pick_c;
    logic             short_nx, reject_nx, none_avail, accept_c;
    logic [SUM_W-1:0] sum_c;

    change_coin_select #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_select (
        .change     (change_q),
        .inv_q      (inv_q),
        .inv_d      (inv_d),
        .inv_n      (inv_n),
        .coin_c     (pick_c),
        .none_avail (none_avail)
    );

    // Overflow of paid is caught by the carry bit of the widened sum.
    assign sum_c    = SUM_W'(paid) + SUM_W'(coin_in);
    assign accept_c = (state == COLLECT) && coin_in_valid && coin_legal(coin_in)
                      && !sum_c[AMT_W] && (paid < cost_q) && !cancel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = COLLECT;
            COLLECT:  if (paid >= cost_q || cancel) state_nx = SELECT;
            SELECT:   state_nx = (change_q == '0 || none_avail) ? DONE : DISPENSE;
            DISPENSE: if (dispense_ready) state_nx = SELECT;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Next values for the datapath registers and registered outputs.
    always_comb begin
        cost_nx   = cost_q;
        paid_nx   = paid;
        change_nx = change_q;
        inv_q_nx  = inv_q;
        inv_d_nx  = inv_d;
        inv_n_nx  = inv_n;
        coin_nx   = dispense_coin;
        short_nx  = short_change;
        rem_nx    = remaining;
        reject_nx = coin_in_valid && !accept_c;
        case (state)
            IDLE: begin
                if (inv_load) begin
                    inv_q_nx = inv_q_d;
                    inv_d_nx = inv_d_d;
                    inv_n_nx = inv_n_d;
                end
                if (start) begin
                    cost_nx  = cost;
                    paid_nx  = '0;
                    short_nx = 1'b0;
                    rem_nx   = '0;
                end
            end
            COLLECT: begin
                if (accept_c) begin
                    paid_nx = sum_c[AMT_W-1:0];
                    case (coin_in)
                        COIN_QUARTER: inv_q_nx = sat_inc(inv_q);
                        COIN_DIME:    inv_d_nx = sat_inc(inv_d);
                        default:      inv_n_nx = sat_inc(inv_n);
                    endcase
                end
                // A completed payment takes precedence over a late cancel.
                if (paid >= cost_q)  change_nx = paid - cost_q;
                else if (cancel)     change_nx = paid;
            end
            SELECT: begin
                if (change_q == '0 || none_avail) begin
                    short_nx = (change_q != '0);
                    rem_nx   = change_q;
                end else begin
                    coin_nx = pick_c;
                end
            end
            DISPENSE: begin
                if (dispense_ready) begin
                    change_nx = change_q - AMT_W'(dispense_coin);
                    coin_nx   = COIN_NONE;
                    case (dispense_coin)
                        COIN_QUARTER: inv_q_nx = inv_q - CNT_W'(1);
                        COIN_DIME:    inv_d_nx = inv_d - CNT_W'(1);
                        default:      inv_n_nx = inv_n - CNT_W'(1);
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cost_q         <= '0;
            change_q       <= '0;
            paid           <= '0;
            inv_q          <= '0;
            inv_d          <= '0;
            inv_n          <= '0;
            dispense_coin  <= COIN_NONE;
            short_change   <= 1'b0;
            remaining      <= '0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
            need_more      <= 1'b0;
            dispense_valid <= 1'b0;
            done           <= 1'b0;
        end else begin
            cost_q         <= cost_nx;
            change_q       <= change_nx;
            paid           <= paid_nx;
            inv_q          <= inv_q_nx;
            inv_d          <= inv_d_nx;
            inv_n          <= inv_n_nx;
            dispense_coin  <= coin_nx;
            short_change   <= short_nx;
            remaining      <= rem_nx;
            coin_reject    <= reject_nx;
            busy           <= (state_nx != IDLE);
            need_more      <= (state_nx == COLLECT) && (paid_nx < cost_nx);
            dispense_valid <= (state_nx == DISPENSE);
            done           <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: payment, exact pay, short change,
// cancel refund, ejector back-pressure, coin reject and mid-dispense reset.
module tb_change_dispense_ctrl;

    localparam int unsigned AMT_W = 6;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [AMT_W-1:0] cost = '0;
    logic             coin_in_valid = 1'b0;
    logic [2:0]       coin_in = '0;
    logic             cancel = 1'b0;
    logic             inv_load = 1'b0;
    logic [CNT_W-1:0] inv_q_d = '0, inv_d_d = '0, inv_n_d = '0;
    logic             dispense_ready = 1'b1;
    logic             busy, need_more, coin_reject, dispense_valid, done, short_change;
    logic [AMT_W-1:0] paid, remaining;
    logic [2:0]       dispense_coin;
    logic [CNT_W-1:0] inv_q, inv_d, inv_n;

    int checks = 0;
    int errors = 0;

    change_dispense_ctrl #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cost(cost),
        .coin_in_valid(coin_in_valid), .coin_in(coin_in), .cancel(cancel),
        .inv_load(inv_load), .inv_q_d(inv_q_d), .inv_d_d(inv_d_d), .inv_n_d(inv_n_d),
        .dispense_ready(dispense_ready), .busy(busy), .paid(paid),
        .need_more(need_more), .coin_reject(coin_reject),
        .dispense_valid(dispense_valid), .dispense_coin(dispense_coin),
        .done(done), .short_change(short_change), .remaining(remaining),
        .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(input string tag);
        int n = 0;
        do begin step(); n++; end while (dispense_valid !== 1'b1 && n < 20);
        chk({tag, "_dv"}, 32'(dispense_valid), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin step(); n++; end while (done !== 1'b1 && n < 20);
        chk({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic begin_txn(input logic [AMT_W-1:0] c, input logic ld,
                             input logic [CNT_W-1:0] q, input logic [CNT_W-1:0] d,
                             input logic [CNT_W-1:0] n);
        start = 1'b1; cost = c; inv_load = ld; inv_q_d = q; inv_d_d = d; inv_n_d = n;
        step();
        start = 1'b0; inv_load = 1'b0;
    endtask

    task automatic insert(input logic [2:0] code);
        coin_in_valid = 1'b1; coin_in = code;
        step();
        coin_in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_paid", 32'(paid), 0);
        chk("rst_dv", 32'(dispense_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_inv_q", 32'(inv_q), 0);
        chk("rst_need_more", 32'(need_more), 0);
        step();
        #2 rst = 1'b0;
        step();

        // 1: cost 7, pay 10, change 2 then 1
        begin_txn(6'd7, 1'b1, 3'd2, 3'd2, 3'd2);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_inv_load", 32'(inv_q), 2);
        chk("t1_need_more", 32'(need_more), 1);
        insert(3'd5);
        chk("t1_paid5", 32'(paid), 5);
        insert(3'd5);
        chk("t1_paid10", 32'(paid), 10);
        chk("t1_need_more_off", 32'(need_more), 0);
        wait_dv("t1_first");
        chk("t1_coin_dime", 32'(dispense_coin), 2);
        wait_dv("t1_second");
        chk("t1_coin_nickel", 32'(dispense_coin), 1);
        wait_done("t1");
        chk("t1_remaining", 32'(remaining), 0);
        chk("t1_short", 32'(short_change), 0);
        chk("t1_inv_q", 32'(inv_q), 4);
        chk("t1_inv_d", 32'(inv_d), 1);
        chk("t1_inv_n", 32'(inv_n), 1);
        step();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_done_pulse", 32'(done), 0);

        // 2: exact payment, done three cycles after the coin
        begin_txn(6'd5, 1'b0, 3'd0, 3'd0, 3'd0);
        insert(3'd5);
        chk("t2_done_n1", 32'(done), 0);
        step();
        chk("t2_done_n2", 32'(done), 0);
        chk("t2_no_dv", 32'(dispense_valid), 0);
        step();
        chk("t2_done_n3", 32'(done), 1);
        chk("t2_remaining", 32'(remaining), 0);
        chk("t2_inv_q", 32'(inv_q), 5);
        step();

        // 3: empty inventory, short change
        begin_txn(6'd3, 1'b1, 3'd0, 3'd0, 3'd0);
        insert(3'd5);
        chk("t3_inv_q", 32'(inv_q), 1);
        wait_done("t3");
        chk("t3_short", 32'(short_change), 1);
        chk("t3_remaining", 32'(remaining), 2);
        step();
        chk("t3_short_held", 32'(short_change), 1);

        // 4: cancel refund of 2 + 1
        begin_txn(6'd10, 1'b1, 3'd0, 3'd0, 3'd0);
        chk("t4_short_cleared", 32'(short_change), 0);
        insert(3'd2);
        insert(3'd1);
        chk("t4_paid", 32'(paid), 3);
        cancel = 1'b1;
        wait_dv("t4_first");
        cancel = 1'b0;
        chk("t4_coin_dime", 32'(dispense_coin), 2);
        wait_dv("t4_second");
        chk("t4_coin_nickel", 32'(dispense_coin), 1);
        wait_done("t4");
        chk("t4_remaining", 32'(remaining), 0);
        chk("t4_short", 32'(short_change), 0);
        step();

        // 5: illegal coin reject, then ejector back-pressure
        begin_txn(6'd10, 1'b1, 3'd1, 3'd0, 3'd0);
        insert(3'd5);
        chk("t5_paid", 32'(paid), 5);
        insert(3'd3);
        chk("t5_reject", 32'(coin_reject), 1);
        chk("t5_paid_same", 32'(paid), 5);
        step();
        chk("t5_reject_pulse", 32'(coin_reject), 0);
        dispense_ready = 1'b0;
        cancel = 1'b1;
        wait_dv("t5");
        cancel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_hold_dv", 32'(dispense_valid), 1);
            chk("t5_hold_coin", 32'(dispense_coin), 5);
            chk("t5_hold_inv", 32'(inv_q), 2);
        end
        dispense_ready = 1'b1;
        step();
        chk("t5_dv_drop", 32'(dispense_valid), 0);
        chk("t5_inv_dec", 32'(inv_q), 1);
        wait_done("t5");
        chk("t5_remaining", 32'(remaining), 0);
        step();

        // 6: reset during DISPENSE, then a fresh transaction
        begin_txn(6'd10, 1'b1, 3'd0, 3'd0, 3'd1);
        insert(3'd1);
        dispense_ready = 1'b0;
        cancel = 1'b1;
        wait_dv("t6");
        cancel = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_dv", 32'(dispense_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_paid", 32'(paid), 0);
        chk("t6_rst_coin", 32'(dispense_coin), 0);
        chk("t6_rst_inv_n", 32'(inv_n), 0);
        #1 rst = 1'b0;
        dispense_ready = 1'b1;
        step();
        begin_txn(6'd2, 1'b0, 3'd0, 3'd0, 3'd0);
        chk("t6_busy", 32'(busy), 1);
        insert(3'd2);
        wait_done("t6");
        chk("t6_remaining", 32'(remaining), 0);
        chk("t6_short", 32'(short_change), 0);
        chk("t6_inv_d", 32'(inv_d), 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
